dtmf_digit_sequencer: RTL and testbench

- Sits directly upstream of the DTMF tone generator and drives the 64x16 number RAM read port.
- Walks the dialled-number words stored in the RAM from address 0 and decodes each keypad code into row/column tone selects.
- Times each tone burst and the inter-digit gap, then stops at a terminator word or after MAX_DIGITS words.

---
 rtl/dtmf_digit_sequencer_if.sv | 25 ++
 rtl/dtmf_digit_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_dtmf_digit_sequencer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dtmf_digit_sequencer_if.sv
// Bus between the DTMF digit sequencer, its number RAM read port and the tone generator.
// The master side controls the sequencer and returns RAM data; the slave side is the sequencer.
interface dtmf_digit_sequencer_if;
    logic        start;
    logic        abort;
    logic        ram_en;
    logic [5:0]  ram_addr;
    logic [15:0] ram_do;
    logic        tone_on;
    logic [1:0]  row_sel;
    logic [1:0]  col_sel;
    logic [3:0]  digit;
    logic        busy;
    logic        done;

    modport master (
        output start, abort, ram_do,
        input  ram_en, ram_addr, tone_on, row_sel, col_sel, digit, busy, done
    );

    modport slave (
        input  start, abort, ram_do,
        output ram_en, ram_addr, tone_on, row_sel, col_sel, digit, busy, done
    );
endinterface

// File: rtl/dtmf_digit_sequencer.sv
// Walks dialled-number words from RAM, decodes each keypad code and times tone/gap bursts.
// Optional macro DTMF_REPEAT_EN: loop the sequence forever instead of finishing with done.
module dtmf_digit_sequencer #(
    parameter logic [15:0] TONE_CYCLES = 16'd800,
    parameter logic [15:0] GAP_CYCLES  = 16'd400,
    parameter logic [6:0]  MAX_DIGITS  = 7'd64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    dtmf_digit_sequencer_if.slave      bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_TONE  = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Keypad code to {row, col} of the standard 4x4 DTMF matrix.
    function automatic logic [3:0] f_decode(input logic [3:0] code);
        logic [3:0] rc;
        case (code)
            4'h1:    rc = {2'd0, 2'd0};
            4'h2:    rc = {2'd0, 2'd1};
            4'h3:    rc = {2'd0, 2'd2};
            4'hC:    rc = {2'd0, 2'd3};
            4'h4:    rc = {2'd1, 2'd0};
            4'h5:    rc = {2'd1, 2'd1};
            4'h6:    rc = {2'd1, 2'd2};
            4'hD:    rc = {2'd1, 2'd3};
            4'h7:    rc = {2'd2, 2'd0};
            4'h8:    rc = {2'd2, 2'd1};
            4'h9:    rc = {2'd2, 2'd2};
            4'hE:    rc = {2'd2, 2'd3};
            4'hA:    rc = {2'd3, 2'd0};
            4'h0:    rc = {2'd3, 2'd1};
            4'hB:    rc = {2'd3, 2'd2};
            4'hF:    rc = {2'd3, 2'd3};
            default: rc = {2'd0, 2'd0};
        endcase
        return rc;
    endfunction

    state_t      r_state;
    logic [5:0]  r_ptr;
    logic [15:0] r_cnt;
    logic        r_ram_en;
    logic        r_tone_on;
    logic [1:0]  r_row_sel;
    logic [1:0]  r_col_sel;
    logic [3:0]  r_digit;
    logic        r_busy;
    logic        r_done;
`ifdef DTMF_REPEAT_EN
    logic        r_wrap;
`endif

    logic [3:0]  w_rc;
    logic        w_last;
    logic        w_unused;

    assign w_rc     = f_decode(bus.ram_do[3:0]);
    assign w_last   = ({1'b0, r_ptr} == (MAX_DIGITS - 7'd1));
    assign w_unused = ^bus.ram_do[14:4];

    assign bus.ram_en   = r_ram_en;
    assign bus.ram_addr = r_ptr;
    assign bus.tone_on  = r_tone_on;
    assign bus.row_sel  = r_row_sel;
    assign bus.col_sel  = r_col_sel;
    assign bus.digit    = r_digit;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

    // Sequencer FSM; every output is a register updated on the transition into its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= 6'd0;
            r_cnt     <= 16'd0;
            r_ram_en  <= 1'b0;
            r_tone_on <= 1'b0;
            r_row_sel <= 2'd0;
            r_col_sel <= 2'd0;
            r_digit   <= 4'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef DTMF_REPEAT_EN
            r_wrap    <= 1'b0;
`endif
        end else if (bus.abort) begin
            // Digit/row/col deliberately hold so the last tone stays observable.
            r_state   <= S_IDLE;
            r_cnt     <= 16'd0;
            r_ram_en  <= 1'b0;
            r_tone_on <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef DTMF_REPEAT_EN
            r_wrap    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state  <= S_FETCH;
                        r_ptr    <= 6'd0;
                        r_ram_en <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                S_FETCH: begin
                    r_ram_en <= 1'b0;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.ram_do[15]) begin
`ifdef DTMF_REPEAT_EN
                        r_state <= S_GAP;
                        r_cnt   <= GAP_CYCLES;
                        r_wrap  <= 1'b1;
`else
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
`endif
                    end else begin
                        r_digit   <= bus.ram_do[3:0];
                        r_row_sel <= w_rc[3:2];
                        r_col_sel <= w_rc[1:0];
                        r_tone_on <= 1'b1;
                        r_cnt     <= TONE_CYCLES;
                        r_state   <= S_TONE;
                    end
                end
                S_TONE: begin
                    if (r_cnt == 16'd1) begin
                        r_tone_on <= 1'b0;
                        r_cnt     <= GAP_CYCLES;
                        r_state   <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == 16'd1) begin
`ifdef DTMF_REPEAT_EN
                        if (r_wrap) begin
                            r_wrap   <= 1'b0;
                            r_ptr    <= 6'd0;
                            r_ram_en <= 1'b1;
                            r_state  <= S_FETCH;
                        end else if (w_last) begin
                            // One extra gap before restarting from address 0.
                            r_wrap <= 1'b1;
                            r_cnt  <= GAP_CYCLES;
                        end else begin
                            r_ptr    <= r_ptr + 6'd1;
                            r_ram_en <= 1'b1;
                            r_state  <= S_FETCH;
                        end
`else
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_ptr    <= r_ptr + 6'd1;
                            r_ram_en <= 1'b1;
                            r_state  <= S_FETCH;
                        end
`endif
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ram_en  <= 1'b0;
                    r_tone_on <= 1'b0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dtmf_digit_sequencer.sv
// Directed bench for dtmf_digit_sequencer with TONE_CYCLES=4, GAP_CYCLES=2, MAX_DIGITS=3.
// A registered RAM model answers reads one clock after ram_en and logs every address read.
module tb_dtmf_digit_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dtmf_digit_sequencer_if bus();

    dtmf_digit_sequencer #(
        .TONE_CYCLES(16'd4),
        .GAP_CYCLES (16'd2),
        .MAX_DIGITS (7'd3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [15:0] ram [0:63];
    logic [15:0] ram_q = 16'd0;
    logic [5:0]  rd_log [$];
    int          checks   = 0;
    int          failures = 0;

    assign bus.ram_do = ram_q;

    always @(posedge clk) begin
        if (bus.ram_en) begin
            ram_q <= ram[bus.ram_addr];
            rd_log.push_back(bus.ram_addr);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 64; i++) ram[i] = v;
    endtask

    task automatic test_reset;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        rst_n     = 1'b0;
        fill(16'h8000);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus.ram_en, bus.ram_addr, bus.tone_on, bus.row_sel, bus.col_sel, bus.digit, bus.busy, bus.done} !== 18'd0)
            begin failures++; $display("FAIL reset_outputs: got %b expected all zero",
                {bus.ram_en, bus.ram_addr, bus.tone_on, bus.row_sel, bus.col_sel, bus.digit, bus.busy, bus.done}); end
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.busy, bus.ram_en, bus.tone_on} !== 3'b000)
            begin failures++; $display("FAIL reset_idle: got %b expected 000", {bus.busy, bus.ram_en, bus.tone_on}); end
    endtask

    task automatic test_sequence;
        logic [3:0] exp_v;
        fill(16'h8000);
        ram[0] = 16'h0001;
        ram[1] = 16'h0005;
        rd_log.delete();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 19; k++) begin
            exp_v = {((k < 4) || (k >= 8 && k < 12)), (k == 6 || k == 14), (k <= 16), (k == 16)};
            checks++;
            if ({bus.tone_on, bus.ram_en, bus.busy, bus.done} !== exp_v)
                begin failures++; $display("FAIL seq_k%0d: got %b expected %b (tone,en,busy,done)",
                    k, {bus.tone_on, bus.ram_en, bus.busy, bus.done}, exp_v); end
            if (k == 0) begin
                checks++;
                if ({bus.row_sel, bus.col_sel, bus.digit} !== 8'h01)
                    begin failures++; $display("FAIL seq_digit1: got %h expected 01", {bus.row_sel, bus.col_sel, bus.digit}); end
            end
            if (k == 8 || k == 13 || k == 18) begin
                checks++;
                if ({bus.row_sel, bus.col_sel, bus.digit} !== 8'h55)
                    begin failures++; $display("FAIL seq_digit5_k%0d: got %h expected 55", k, {bus.row_sel, bus.col_sel, bus.digit}); end
            end
            tick();
        end
        checks++;
        if (rd_log.size() != 3 || rd_log[0] != 6'd0 || rd_log[1] != 6'd1 || rd_log[2] != 6'd2)
            begin failures++; $display("FAIL seq_reads: got %0d reads expected 3 at 0,1,2", rd_log.size()); end
    endtask

    task automatic test_terminator;
        logic [3:0] exp_t [4];
        exp_t = '{4'b0110, 4'b0010, 4'b0011, 4'b0000};
        fill(16'h8000);
        rd_log.delete();
        bus.start = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({bus.tone_on, bus.ram_en, bus.busy, bus.done} !== exp_t[k])
                begin failures++; $display("FAIL term_k%0d: got %b expected %b (tone,en,busy,done)",
                    k, {bus.tone_on, bus.ram_en, bus.busy, bus.done}, exp_t[k]); end
            if (k == 1) bus.start = 1'b0;
            tick();
        end
        checks++;
        if (rd_log.size() != 1 || rd_log[0] != 6'd0)
            begin failures++; $display("FAIL term_reads: got %0d reads expected 1 at addr 0", rd_log.size()); end
    endtask

    task automatic test_max_digits;
        logic [3:0] exp_v;
        fill(16'h000B);
        rd_log.delete();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 25; k++) begin
            exp_v = {((k % 8 < 4) && (k < 24)), (k == 6 || k == 14), (k <= 22), (k == 22)};
            checks++;
            if ({bus.tone_on, bus.ram_en, bus.busy, bus.done} !== exp_v)
                begin failures++; $display("FAIL max_k%0d: got %b expected %b (tone,en,busy,done)",
                    k, {bus.tone_on, bus.ram_en, bus.busy, bus.done}, exp_v); end
            if (k == 16) begin
                checks++;
                if ({bus.row_sel, bus.col_sel, bus.digit} !== 8'hEB)
                    begin failures++; $display("FAIL max_digitB: got %h expected eb", {bus.row_sel, bus.col_sel, bus.digit}); end
            end
            tick();
        end
        checks++;
        if (rd_log.size() != 3 || rd_log[0] != 6'd0 || rd_log[1] != 6'd1 || rd_log[2] != 6'd2)
            begin failures++; $display("FAIL max_reads: got %0d reads expected 3 at 0,1,2", rd_log.size()); end
    endtask

    task automatic test_abort;
        logic seen;
        fill(16'h8000);
        ram[0] = 16'h0007;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checks++;
        if ({bus.tone_on, bus.busy, bus.done, bus.ram_en} !== 4'b0000)
            begin failures++; $display("FAIL abort_stop: got %b expected 0000", {bus.tone_on, bus.busy, bus.done, bus.ram_en}); end
        checks++;
        if ({bus.row_sel, bus.col_sel, bus.digit} !== 8'h87)
            begin failures++; $display("FAIL abort_hold: got %h expected 87", {bus.row_sel, bus.col_sel, bus.digit}); end
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (bus.done || bus.busy) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen !== 1'b0)
            begin failures++; $display("FAIL abort_quiet: got %b expected 0", seen); end
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        checks++;
        if ({bus.busy, bus.ram_en} !== 2'b00)
            begin failures++; $display("FAIL abort_vs_start: got %b expected 00", {bus.busy, bus.ram_en}); end
        rd_log.delete();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if ({bus.ram_en, bus.ram_addr} !== 7'b1_000000)
            begin failures++; $display("FAIL abort_restart: got %b expected 1000000", {bus.ram_en, bus.ram_addr}); end
        repeat (12) tick();
        checks++;
        if (bus.busy !== 1'b0 || rd_log.size() != 2 || rd_log[1] != 6'd1)
            begin failures++; $display("FAIL abort_rerun: got busy=%b reads=%0d expected 0 and 2", bus.busy, rd_log.size()); end
    endtask

    task automatic test_async_reset;
        fill(16'h8000);
        ram[0] = 16'h0007;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        repeat (4) tick();
        checks++;
        if ({bus.tone_on, bus.busy} !== 2'b01)
            begin failures++; $display("FAIL arst_in_gap: got %b expected 01", {bus.tone_on, bus.busy}); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.ram_en, bus.ram_addr, bus.tone_on, bus.row_sel, bus.col_sel, bus.digit, bus.busy, bus.done} !== 18'd0)
            begin failures++; $display("FAIL arst_outputs: got %b expected all zero",
                {bus.ram_en, bus.ram_addr, bus.tone_on, bus.row_sel, bus.col_sel, bus.digit, bus.busy, bus.done}); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.busy, bus.ram_en, bus.tone_on, bus.done} !== 4'b0000)
            begin failures++; $display("FAIL arst_idle: got %b expected 0000", {bus.busy, bus.ram_en, bus.tone_on, bus.done}); end
    endtask

`ifdef DTMF_REPEAT_EN
    task automatic test_repeat;
        logic [3:0] exp_v;
        fill(16'h8000);
        ram[0] = 16'h0009;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            exp_v = {((k >= 2) && ((k - 2) % 12 < 4)), ((k % 12 == 0) || (k % 12 == 8)), 1'b1, 1'b0};
            checks++;
            if ({bus.tone_on, bus.ram_en, bus.busy, bus.done} !== exp_v)
                begin failures++; $display("FAIL rep_k%0d: got %b expected %b (tone,en,busy,done)",
                    k, {bus.tone_on, bus.ram_en, bus.busy, bus.done}, exp_v); end
            if (k == 14 || k == 26) begin
                checks++;
                if ({bus.row_sel, bus.col_sel, bus.digit} !== 8'hA9)
                    begin failures++; $display("FAIL rep_digit9_k%0d: got %h expected a9", k, {bus.row_sel, bus.col_sel, bus.digit}); end
            end
            if (k == 24) begin
                checks++;
                if (bus.ram_addr !== 6'd0)
                    begin failures++; $display("FAIL rep_addr_wrap: got %0d expected 0", bus.ram_addr); end
            end
            tick();
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checks++;
        if ({bus.busy, bus.tone_on, bus.done} !== 3'b000)
            begin failures++; $display("FAIL rep_abort: got %b expected 000", {bus.busy, bus.tone_on, bus.done}); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef DTMF_REPEAT_EN
        test_repeat();
        test_async_reset();
`else
        test_sequence();
        test_terminator();
        test_max_digits();
        test_abort();
        test_async_reset();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
